// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined reduction gate.
// Holds the op encoding, the identity element and the per-level tree widths.
package reduce_pkg;

  typedef enum logic [1:0] {
    RED_AND  = 2'b00,
    RED_OR   = 2'b01,
    RED_XOR  = 2'b10,
    RED_NAND = 2'b11
  } red_op_t;

  // Identity element used to pad odd element counts.
  function automatic logic red_identity(input red_op_t op);
    return (op == RED_AND) || (op == RED_NAND);
  endfunction

  // NAND folds as AND; the final stage applies the inversion.
  function automatic logic red_combine(input red_op_t op, input logic a, input logic b);
    case (op)
      RED_OR:  return a | b;
      RED_XOR: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Element count entering tree level 'level' for a 'width'-bit input.
  function automatic int red_level_width(input int width, input int level);
    int w;
    w = width;
    for (int i = 0; i < level; i++) w = (w + 1) / 2;
    return w;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One reduction tree level: pairwise combine, then register data, op and valid.
// All stages share one advance enable so bubbles shift like real entries.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W = 8,
  parameter bit LAST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic                     in_valid,
  input  red_op_t                  in_op,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  output red_op_t                  out_op,
  output logic [(IN_W+1)/2-1:0]    out_data
);

  localparam int OUT_W = (IN_W + 1) / 2;
  localparam int PAD_W = 2 * OUT_W;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] reduced;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    padded             = {PAD_W{red_identity(in_op)}};
    reduced            = '0;
    padded[IN_W-1:0]   = in_data;
    for (int i = 0; i < OUT_W; i++) begin
      reduced[i] = red_combine(in_op, padded[2*i], padded[2*i+1]);
    end
    if (LAST && (in_op == RED_NAND)) reduced = ~reduced;
  end

  // NOTE: sequential state uses non-blocking assignments; data/op are reset too so
  // the outputs read as zero after reset rather than holding stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= RED_AND;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_data  <= reduced;
    end
  end

endmodule

// File: rtl/pipelined_reduce_gate.sv
// N-input AND/OR/XOR/NAND reduction tree, one register per level, valid/ready both sides.
// Optional REDUCE_HIT_COUNT_EN adds a saturating count of accepted results equal to 1.
module pipelined_reduce_gate
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [1:0]       out_op
`ifdef REDUCE_HIT_COUNT_EN
  ,
  output logic [15:0]      hit_count
`endif
);

  localparam int STAGES = $clog2(WIDTH);

  logic adv;

  // Single global stall: the whole tree moves or the whole tree holds.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : gen_level
    localparam int IN_W  = red_level_width(WIDTH, k);
    localparam int OUT_W = (IN_W + 1) / 2;

    logic [IN_W-1:0]  s_in;
    logic             v_in;
    red_op_t          op_in;
    logic [OUT_W-1:0] s_out;
    logic             v_out;
    red_op_t          op_out;

    if (k == 0) begin : g_first
      assign s_in  = in_data;
      assign v_in  = in_valid & in_ready;
      assign op_in = red_op_t'(in_op);
    end else begin : g_next
      assign s_in  = gen_level[k-1].s_out;
      assign v_in  = gen_level[k-1].v_out;
      assign op_in = gen_level[k-1].op_out;
    end

    reduce_stage #(
      .IN_W (IN_W),
      .LAST (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (v_in),
      .in_op     (op_in),
      .in_data   (s_in),
      .out_valid (v_out),
      .out_op    (op_out),
      .out_data  (s_out)
    );
  end

  assign out_valid = gen_level[STAGES-1].v_out;
  assign out_s     = gen_level[STAGES-1].s_out[0];
  assign out_op    = gen_level[STAGES-1].op_out;

`ifdef REDUCE_HIT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= 16'd0;
    end else if (out_valid && out_ready && out_s && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule
